// File: rtl/dm_access_ctrl_if.sv
// CPU load/store request channel plus the word-wide data-memory port.
// The controller takes the slave view; the requester/memory side takes the master view.
interface dm_access_ctrl_if #(parameter int DM_AW = 10);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              err;
    logic [DM_AW-1:0]  dm_addr;
    logic [31:0]       dm_din;
    logic              dm_wr;
    logic              dm_rd;
    logic [31:0]       dm_dout;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_dout,
        input  req_ready, rdata, rdata_valid, err, dm_addr, dm_din, dm_wr, dm_rd
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_dout,
        output req_ready, rdata, rdata_valid, err, dm_addr, dm_din, dm_wr, dm_rd
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store controller for a word-only data memory: sub-word stores go through
// read-modify-write, loads are lane-extracted and zero/sign-extended.
module dm_access_ctrl #(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_access_ctrl_if.slave  bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LD     = 3'd1;
    localparam logic [2:0] LD_FMT = 3'd2;
    localparam logic [2:0] ST_W   = 3'd3;
    localparam logic [2:0] RMW_RD = 3'd4;
    localparam logic [2:0] RMW_WR = 3'd5;

    logic [2:0]       state_reg, state_next;
    logic             we_reg;
    logic [1:0]       size_reg;
    logic             uns_reg;
    logic [DM_AW+1:0] addr_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;
    logic             rdata_valid_reg;
    logic             err_reg;

    logic             transfer;
    logic             req_bad;
    logic [31:0]      ld_shift;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_fmt;
    logic [31:0]      rmw_merged;
    logic             unused_addr_hi;

    // High address bits alias onto the same memory word.
    assign unused_addr_hi = ^bus.req_addr[31:DM_AW+2];

    assign transfer = bus.req_valid && (state_reg == IDLE);
    assign req_bad  = (bus.req_size == 2'b11)
                   || ((bus.req_size == 2'b01) && bus.req_addr[0])
                   || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (transfer && !req_bad) begin
                    if (!bus.req_we)
                        state_next = LD;
                    else if (bus.req_size == 2'b10)
                        state_next = ST_W;
                    else
                        state_next = RMW_RD;
                end
            end
            LD:      state_next = LD_FMT;
            LD_FMT:  state_next = IDLE;
            ST_W:    state_next = IDLE;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ld_shift = bus.dm_dout >> {addr_reg[1:0], 3'b000};
    assign ld_byte  = ld_shift[7:0];
    assign ld_half  = addr_reg[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];

    always_comb begin
        case (size_reg)
            2'b00:   ld_fmt = {{24{~uns_reg & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{~uns_reg & ld_half[15]}}, ld_half};
            default: ld_fmt = bus.dm_dout;
        endcase
    end

    // Per-lane replace for the write half of a read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_new;
            assign lane_hit = (size_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi))
                                                  : (addr_reg[1] == 1'(gi / 2));
            assign lane_new = (size_reg == 2'b00) ? wdata_reg[7:0]
                                                  : wdata_reg[8*(gi%2) +: 8];
            assign rmw_merged[8*gi +: 8] = lane_hit ? lane_new : bus.dm_dout[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            we_reg          <= 1'b0;
            size_reg        <= 2'b00;
            uns_reg         <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rdata_valid_reg <= (state_reg == LD_FMT);
            err_reg         <= transfer && req_bad;
            if (transfer) begin
                we_reg    <= bus.req_we;
                size_reg  <= bus.req_size;
                uns_reg   <= bus.req_unsigned;
                addr_reg  <= bus.req_addr[DM_AW+1:0];
                wdata_reg <= bus.req_wdata;
            end
            if (state_reg == LD_FMT)
                rdata_reg <= ld_fmt;
        end
    end

    // we_reg is folded into the state path; kept so the capture set mirrors the request.
    logic unused_we;
    assign unused_we = we_reg;

    assign bus.req_ready   = (state_reg == IDLE);
    assign bus.dm_rd       = (state_reg == LD) || (state_reg == RMW_RD);
    assign bus.dm_wr       = (state_reg == ST_W) || (state_reg == RMW_WR);
    assign bus.dm_addr     = addr_reg[DM_AW+1:2];
    assign bus.dm_din      = (state_reg == RMW_WR) ? rmw_merged : wdata_reg;
    assign bus.rdata       = rdata_reg;
    assign bus.rdata_valid = rdata_valid_reg;
    assign bus.err         = err_reg;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a request-level model predicts every output
// per cycle; literal checks pin the model on the planned scenarios.
module tb_dm_access_ctrl;

    localparam int DM_AW = 10;
    localparam int NC    = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dm_access_ctrl_if #(.DM_AW(DM_AW)) bus ();

    dm_access_ctrl #(.DM_AW(DM_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory the controller talks to.
    logic [31:0] ram [0:(1<<DM_AW)-1];
    always @(posedge clk) begin
        if (bus.dm_wr) ram[bus.dm_addr] <= bus.dm_din;
        if (bus.dm_rd) bus.dm_dout <= ram[bus.dm_addr];
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- request-level model ----------------
    bit [31:0] mm [0:(1<<DM_AW)-1];
    bit        exp_rd  [0:NC-1];
    bit        exp_wr  [0:NC-1];
    bit        exp_err [0:NC-1];
    bit        exp_rv  [0:NC-1];
    bit [9:0]  exp_addr[0:NC-1];
    bit [31:0] exp_din [0:NC-1];
    bit [31:0] m_rdata   = 0;
    int        busy_until = 0;
    int        p_wr_cyc = -1, p_rmw_cyc = -1, p_ld_cyc = -1;
    bit [9:0]  p_word;
    bit [31:0] p_val;
    bit [1:0]  p_size, p_off;
    bit        p_uns;

    function automatic bit [31:0] ld_val(bit [31:0] w, bit [1:0] sz, bit uns, bit [1:0] off);
        bit [7:0]  b;
        bit [15:0] h;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic bit [31:0] st_val(bit [31:0] w, bit [1:0] sz, bit [1:0] off, bit [31:0] wd);
        bit [31:0] r;
        r = w;
        if (sz == 2'd0) r[8*off +: 8] = wd[7:0];
        else            r[16*off[1] +: 16] = wd[15:0];
        return r;
    endfunction

    always @(posedge clk) begin
        bit        legal;
        bit [9:0]  w;
        int        n;
        cyc++;
        n = cyc;
        if (rst_n && n + 2 < NC) begin
            if (n == p_rmw_cyc) begin
                p_val = st_val(mm[p_word], p_size, p_off, p_val);
                exp_din[n] = p_val;
            end
            if (n == p_wr_cyc) begin
                mm[p_word] = p_val;
                p_wr_cyc = -1;
            end
            if (n == p_ld_cyc) m_rdata = ld_val(mm[p_word], p_size, p_uns, p_off);

            if (bus.req_valid && (n - 1) >= busy_until) begin
                legal = !(bus.req_size == 2'd3
                       || (bus.req_size == 2'd1 && bus.req_addr[0])
                       || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0));
                w = bus.req_addr[11:2];
                if (!legal) begin
                    exp_err[n] = 1;
                end else begin
                    p_word = w;
                    p_size = bus.req_size;
                    p_off  = bus.req_addr[1:0];
                    p_uns  = bus.req_unsigned;
                    p_val  = bus.req_wdata;
                    exp_addr[n] = w;
                    if (!bus.req_we) begin
                        exp_rd[n] = 1;
                        exp_rv[n+2] = 1;
                        p_ld_cyc = n + 2;
                        busy_until = n + 2;
                    end else if (bus.req_size == 2'd2) begin
                        exp_wr[n] = 1;
                        exp_din[n] = bus.req_wdata;
                        p_wr_cyc = n + 1;
                        busy_until = n + 1;
                    end else begin
                        exp_rd[n] = 1;
                        exp_wr[n+1] = 1;
                        exp_addr[n+1] = w;
                        p_rmw_cyc = n + 1;
                        p_wr_cyc = n + 2;
                        busy_until = n + 2;
                    end
                end
            end
        end
    end

    // Reset aborts whatever is in flight, including an unfinished write.
    always @(negedge rst_n) begin
        busy_until = 0;
        p_wr_cyc = -1;
        p_rmw_cyc = -1;
        p_ld_cyc = -1;
        m_rdata = 0;
        for (int c = cyc; c < NC; c++) begin
            exp_rd[c] = 0; exp_wr[c] = 0; exp_err[c] = 0; exp_rv[c] = 0;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("rst_dm_rd", {31'd0, bus.dm_rd}, 32'd0);
            chk("rst_dm_wr", {31'd0, bus.dm_wr}, 32'd0);
            chk("rst_err", {31'd0, bus.err}, 32'd0);
            chk("rst_rvalid", {31'd0, bus.rdata_valid}, 32'd0);
            chk("rst_rdata", bus.rdata, 32'd0);
        end else if (cyc < NC) begin
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, cyc >= busy_until});
            chk("dm_rd", {31'd0, bus.dm_rd}, {31'd0, exp_rd[cyc]});
            chk("dm_wr", {31'd0, bus.dm_wr}, {31'd0, exp_wr[cyc]});
            chk("err", {31'd0, bus.err}, {31'd0, exp_err[cyc]});
            chk("rdata_valid", {31'd0, bus.rdata_valid}, {31'd0, exp_rv[cyc]});
            chk("rdata", bus.rdata, m_rdata);
            if (exp_rd[cyc] || exp_wr[cyc])
                chk("dm_addr", {22'd0, bus.dm_addr}, {22'd0, exp_addr[cyc]});
            if (exp_wr[cyc])
                chk("dm_din", bus.dm_din, exp_din[cyc]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input bit we, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd);
        bit done;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        $display("req we=%0d size=%0d uns=%0d addr=%h wdata=%h", we, sz, uns, a, wd);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.req_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << DM_AW); i++) ram[i] = 32'h0;
        bus.dm_dout      = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // word store then word load
        req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF);
        idle(1);
        req(0, 2'd2, 0, 32'h100, 32'h0);
        idle(4);
        chk("t1_ram", ram[10'h040], 32'hDEADBEEF);
        chk("t1_rdata", bus.rdata, 32'hDEADBEEF);

        // byte store via RMW, signed/unsigned byte loads
        req(1, 2'd2, 0, 32'h100, 32'h11223344);
        req(1, 2'd0, 0, 32'h101, 32'h000000A5);
        idle(3);
        chk("t2_ram", ram[10'h040], 32'h1122A544);
        req(0, 2'd0, 0, 32'h101, 32'h0);
        idle(4);
        chk("t2_lb", bus.rdata, 32'hFFFFFFA5);
        req(0, 2'd0, 1, 32'h101, 32'h0);
        idle(4);
        chk("t2_lbu", bus.rdata, 32'h000000A5);

        // upper halfword store and loads
        req(1, 2'd1, 0, 32'h102, 32'h00008001);
        idle(3);
        chk("t3_ram", ram[10'h040], 32'h8001A544);
        req(0, 2'd1, 0, 32'h102, 32'h0);
        idle(4);
        chk("t3_lh", bus.rdata, 32'hFFFF8001);
        req(0, 2'd1, 1, 32'h102, 32'h0);
        idle(4);
        chk("t3_lhu", bus.rdata, 32'h00008001);

        // misaligned / illegal requests
        req(0, 2'd2, 0, 32'h103, 32'h0);
        idle(1);
        req(1, 2'd1, 0, 32'h101, 32'h0000FFFF);
        idle(1);
        req(1, 2'd3, 0, 32'h100, 32'hFFFFFFFF);
        idle(3);
        chk("t4_ram", ram[10'h040], 32'h8001A544);
        chk("t4_rdata", bus.rdata, 32'h00008001);

        // back-to-back with valid held: store then dependent load
        req(1, 2'd0, 0, 32'h104, 32'h0000005A);
        req(0, 2'd2, 0, 32'h104, 32'h0);
        idle(4);
        chk("t5_rdata", bus.rdata, 32'h0000005A);

        // reset during the write half of a RMW
        req(1, 2'd0, 0, 32'h108, 32'h00000077);
        @(posedge clk);
        #2 rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("t6_dm_wr_drop", {31'd0, bus.dm_wr}, 32'd0);
        chk("t6_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        chk("t6_ram", ram[10'h042], 32'h0);
        req(0, 2'd2, 0, 32'h104, 32'h0);
        idle(4);
        chk("t6_post_rst_lw", bus.rdata, 32'h0000005A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Load/store controller sitting directly upstream of the 4 KB word-organised data memory. Accepts byte/halfword/word load and store requests from the CPU memory stage and converts them into word-wide memory accesses. Sub-word stores use a read-modify-write sequence, because the data memory only writes whole words. Loads are extracted, zero/sign-extended and returned with a valid pulse.

Parameters:
DM_AW, 10, word-address width driven to data memory (byte address bits [DM_AW+1:2])

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept (state IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rdata  out  32  formatted load data
rdata_valid  out  1  one-cycle pulse, rdata valid
err  out  1  one-cycle pulse, misaligned or illegal-size request
dm_addr  out  DM_AW  word address to memory
dm_din  out  32  write data to memory
dm_wr  out  1  memory write enable
dm_rd  out  1  memory read enable
dm_dout  in  32  memory read data (valid the cycle after the edge sampling dm_rd)

Behaviour:
- Handshake: transfer when req_valid && req_ready at a rising edge. req_ready = (state == IDLE), combinational. Inputs are captured into internal registers at transfer; the requester changes req_* only after transfer.
- Address mapping: dm_addr = captured addr[DM_AW+1:2]. addr[31:DM_AW+2] is ignored (aliases). Little-endian: byte lane n = bits [8n+7:8n], selected by addr[1:0]; halfword at addr[1]=0 is [15:0], at addr[1]=1 is [31:16].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; size 11 is always illegal. A bad request is still accepted, but:
  - err pulses high in the cycle after the transfer;
  - no dm_rd/dm_wr is issued;
  - state stays IDLE.
- States (dm_rd/dm_wr combinational from state; dm_addr/dm_din from captured registers):
  - IDLE: dm_rd=dm_wr=0. On a legal transfer: load -> LD; word store -> ST_W; byte/half store -> RMW_RD.
  - LD: dm_rd=1. -> LD_FMT.
  - LD_FMT: dm_dout is valid. At the edge, rdata <= extracted lane(s), extended per req_unsigned (word passes through); rdata_valid <= 1. -> IDLE.
  - ST_W: dm_wr=1, dm_din=wdata. -> IDLE.
  - RMW_RD: dm_rd=1. -> RMW_WR.
  - RMW_WR: dm_wr=1, dm_din = dm_dout with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]. -> IDLE.
- Latency (transfer at edge N):
  - load: rdata_valid high in the cycle after edge N+2; busy 2 cycles;
  - word store: written at edge N+1;
  - sub-word store: written at edge N+2.
- Back-to-back: a new request can transfer in the IDLE cycle in which rdata_valid is high. A load immediately after a store to the same word returns the new data, because the write completes before the read is issued.
- rdata holds its value until the next load completes. rdata_valid and err are never high together.
- Reset (async, rst_n=0):
  - state=IDLE; rdata=0; rdata_valid=0; err=0; captured registers=0.
  - dm_wr and dm_rd drop immediately, even mid-RMW, so an interrupted store writes nothing.
  - req_ready=1 while in reset.

Test Plan:
1. sw 0xDEADBEEF @0x100, then lw @0x100 -> one dm_wr pulse with dm_addr=0x040; rdata=0xDEADBEEF, rdata_valid in the cycle after edge N+2 of the load.
2. Memory word @0x100 = 0x11223344; sb 0xA5 @0x101 -> dm_rd then dm_wr, memory=0x1122A544. lb @0x101 -> 0xFFFFFFA5; lbu @0x101 -> 0x000000A5.
3. sh 0x8001 @0x102 over 0x1122A544 -> memory 0x8001A544. lh @0x102 -> 0xFFFF8001; lhu -> 0x00008001.
4. lw @0x103, sh @0x101, size=11 @0x100 -> each gives one err pulse; no dm_rd/dm_wr; req_ready stays 1; rdata unchanged.
5. req_valid held continuously: sb 0x5A @0x104, then lw @0x104 over initial 0 -> load transfers in the IDLE cycle after RMW_WR; rdata=0x0000005A.
6. rst_n=0 asserted during RMW_WR -> dm_wr falls immediately; memory word unchanged; all outputs 0 and req_ready=1 until release.
